instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 8-bit processor. It owns the program counter and fetches each instruction into the instruction register. It steps the datapath through decode, execute, memory, input and write-back phases using the combinational decoder's control flags. It sits between instruction memory, data memory, the register file write port and the external input port, and applies a ready/valid handshake on every external wait.

---
 rtl/instr_sequencer.sv | 173 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute sequencer for the 8-bit processor
//
// Owns the program counter and the instruction register. Each instruction runs
// FETCH -> DECODE -> EXEC, then optionally MEM / IN / WB, and retires.
// Optional feature: define SEQ_WATCHDOG_EN to bound FETCH/MEM waits with a
// sticky FAULT state.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   run                 allow fetch of the next instruction (sampled in IDLE / at retire)
//   instr, imem_ready   instruction memory read data and its valid
//   imem_req            instruction fetch request
//   target, eq          jump target and equality flag from the datapath
//   dec_*               decoder flags, combinational from ir[7:5]
//   dmem_req, dmem_we   data memory request / write qualifier, dmem_ready completes it
//   in_valid, in_ack    external input handshake (in_ack is combinational on in_valid)
//   reg_we              register file write strobe
//   pc, ir              program counter and instruction register
//   instr_done          one-cycle pulse in the retiring cycle
//   fault               sticky watchdog fault
module instr_sequencer #(
    parameter int PC_W      = 8,
    parameter int RESET_PC  = 0,
    parameter int WD_CYCLES = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [7:0]      instr,
    input  logic            imem_ready,
    input  logic [PC_W-1:0] target,
    input  logic            eq,
    input  logic            dec_j,
    input  logic            dec_jc,
    input  logic            dec_neq,
    input  logic            dec_rm,
    input  logic            dec_wm,
    input  logic            dec_sin,
    input  logic            dec_sout,
    input  logic            dec_wr,
    input  logic            dec_ina,
    input  logic            dmem_ready,
    input  logic            in_valid,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            in_ack,
    output logic            reg_we,
    output logic            instr_done,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_IN, S_WB, S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            retire;
    logic            imem_req_q, dmem_req_q, dmem_we_q, reg_we_q;

    // dec_ina selects the datapath input mux; the sequencer does not need it.
    logic unused_dec_ina;
    assign unused_dec_ina = dec_ina;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            waiting;
`else
    logic unused_wd;
    assign unused_wd = (WD_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                // First matching flag wins; jumps retire straight from EXEC.
                if (dec_j) begin
                    pc_d   = target;
                    retire = 1'b1;
                end else if (dec_jc) begin
                    if (eq ^ dec_neq) pc_d = target;
                    retire = 1'b1;
                end else if (dec_wm || dec_rm) begin
                    state_d = S_MEM;
                end else if (dec_sin) begin
                    state_d = S_IN;
                end else if (dec_wr || dec_sout) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (dec_rm) state_d = S_WB;
                    else        retire  = 1'b1;
                end
            end
            S_IN:     if (in_valid) state_d = S_WB;
            S_WB:     retire = 1'b1;
            default:  state_d = state_q;
        endcase
        // run only matters at the retire decision, so a drop mid-instruction is harmless.
        if (retire) state_d = run ? S_FETCH : S_IDLE;
`ifdef SEQ_WATCHDOG_EN
        waiting = ((state_q == S_FETCH) && !imem_ready) ||
                  ((state_q == S_MEM)   && !dmem_ready);
        wd_d    = waiting ? wd_q + WD_W'(1) : '0;
        if (waiting && (wd_q == WD_W'(WD_CYCLES - 1))) state_d = S_FAULT;
`endif
    end

    // Request/strobe outputs are registered from the next state so they are
    // glitch-free Moore decodes of state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_W'(RESET_PC);
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            imem_req_q <= (state_d == S_FETCH);
            dmem_req_q <= (state_d == S_MEM);
            dmem_we_q  <= (state_d == S_MEM) && dec_wm;
            reg_we_q   <= (state_d == S_WB);
`ifdef SEQ_WATCHDOG_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign pc         = pc_q;
    assign ir         = ir_q;
    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign reg_we     = reg_we_q;
    assign in_ack     = (state_q == S_IN) && in_valid;
    assign instr_done = retire;
`ifdef SEQ_WATCHDOG_EN
    assign fault      = (state_q == S_FAULT);
`else
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic       clock = 1'b0;
    logic       reset, run, imem_ready, eq, dmem_ready, in_valid;
    logic [7:0] instr, target;
    logic       dec_j, dec_jc, dec_neq, dec_rm, dec_wm, dec_sin, dec_sout, dec_wr, dec_ina;
    logic [7:0] pc, ir;
    logic       imem_req, dmem_req, dmem_we, in_ack, reg_we, instr_done, fault;
    logic       noise;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_pc;

    instr_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .instr(instr), .imem_ready(imem_ready),
        .target(target), .eq(eq),
        .dec_j(dec_j), .dec_jc(dec_jc), .dec_neq(dec_neq), .dec_rm(dec_rm), .dec_wm(dec_wm),
        .dec_sin(dec_sin), .dec_sout(dec_sout), .dec_wr(dec_wr), .dec_ina(dec_ina),
        .dmem_ready(dmem_ready), .in_valid(in_valid),
        .pc(pc), .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .in_ack(in_ack), .reg_we(reg_we), .instr_done(instr_done), .fault(fault)
    );

    always #5 clock = ~clock;

    // Opcode map (ir[7:5]): 0 NOP, 1 R, 2 MW, 3 MR, 4 J, 5 JCE, 6 JCN, 7 MFI.
    // 'noise' raises extra lower-priority flags to exercise dispatch priority.
    always_comb begin
        dec_j = 0; dec_jc = 0; dec_neq = 0; dec_rm = 0; dec_wm = 0;
        dec_sin = 0; dec_sout = 0; dec_wr = 0; dec_ina = 0;
        case (ir[7:5])
            3'd1: begin dec_wr = 1; dec_sout = noise; end
            3'd2: begin dec_wm = 1; dec_sin = noise; end
            3'd3: begin dec_rm = 1; dec_wr = 1; dec_sin = noise; end
            3'd4: begin dec_j = 1; dec_jc = noise; dec_wr = noise; end
            3'd5: begin dec_jc = 1; dec_rm = noise; end
            3'd6: begin dec_jc = 1; dec_neq = 1; dec_wm = noise; end
            3'd7: begin dec_sin = 1; dec_wr = 1; dec_ina = 1; dec_sout = noise; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting in its FETCH cycle (called just after a posedge).
    task automatic run_instr(input logic [2:0] op, input logic [7:0] tgt, input logic eqv,
                             input int wi, input int wd, input int wn, input logic run_after);
        int   cyc = 0, n_if = 0, n_dm = 0, n_we = 0, n_rw = 0, n_ack = 0, ack_cyc = 0;
        int   total;
        logic done = 0;
        logic taken;
        logic [7:0] word;
        word   = {op, 5'($urandom)};
        instr  = word;
        target = tgt;
        eq     = eqv;
        noise  = 1'($urandom);
        // Reference: cycle count and side effects from the instruction class alone.
        case (op)
            3'd1, 3'd2: total = 4;
            3'd3, 3'd7: total = 5;
            default:    total = 3;
        endcase
        total = total + wi + ((op == 3'd2 || op == 3'd3) ? wd : 0) + ((op == 3'd7) ? wn : 0);
        taken  = (op == 3'd4) || (op == 3'd5 && eqv) || (op == 3'd6 && !eqv);
        exp_pc = taken ? tgt : exp_pc + 8'd1;
        while (!done && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) run = run_after;
            imem_ready = imem_req && (n_if >= wi);
            dmem_ready = dmem_req && (n_dm >= wd);
            in_valid   = (op == 3'd7) ? (cyc >= wi + 4 + wn) : 1'($urandom);
            #1;
            if (imem_req) n_if++;
            if (dmem_req) n_dm++;
            if (dmem_we)  n_we++;
            if (reg_we)   n_rw++;
            if (in_ack) begin n_ack++; ack_cyc = cyc; end
            if (instr_done) done = 1;
        end
        check("retired", done, 1);
        check("cycles", cyc, total);
        check("imem_req_cycles", n_if, wi + 1);
        check("dmem_req_cycles", n_dm, (op == 3'd2 || op == 3'd3) ? wd + 1 : 0);
        check("dmem_we_cycles", n_we, (op == 3'd2) ? wd + 1 : 0);
        check("reg_we_pulses", n_rw, (op == 3'd1 || op == 3'd3 || op == 3'd7) ? 1 : 0);
        check("in_ack_pulses", n_ack, (op == 3'd7) ? 1 : 0);
        if (op == 3'd7) check("in_ack_cycle", ack_cyc, wi + 4 + wn);
        @(posedge clock);
        #1;
        in_valid   = 0;
        dmem_ready = 0;
        check("pc", pc, exp_pc);
        check("ir", ir, word);
        check("fault_clear", fault, 0);
        check("next_fetch", imem_req, run_after);
        if (!run_after) begin
            repeat (2) @(posedge clock);
            #1;
            check("idle_no_fetch", imem_req, 0);
            run = 1;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int cyc;
        reset = 1; run = 0; instr = 0; imem_ready = 0; target = 0; eq = 0;
        dmem_ready = 0; in_valid = 0; noise = 0;
        exp_pc = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_strobes", {imem_req, dmem_req, dmem_we, in_ack, reg_we, instr_done, fault}, 0);
        reset = 0;
        @(posedge clock);
        #1;
        check("idle_wait_run", imem_req, 0);
        run = 1;
        @(posedge clock);
        #1;
        check("fetch_after_run", imem_req, 1);

        // Directed: jumps, conditional jumps both ways, waits, wrap, run drop.
        run_instr(3'd4, 8'h42, 0, 0, 0, 0, 1);
        run_instr(3'd4, 8'h10, 0, 0, 0, 0, 1);
        run_instr(3'd6, 8'h77, 1, 0, 0, 0, 1);
        run_instr(3'd4, 8'h10, 0, 0, 0, 0, 1);
        run_instr(3'd6, 8'h55, 0, 0, 0, 0, 1);
        run_instr(3'd4, 8'h10, 0, 0, 0, 0, 1);
        run_instr(3'd5, 8'h66, 1, 0, 0, 0, 1);
        run_instr(3'd4, 8'h10, 0, 0, 0, 0, 1);
        run_instr(3'd5, 8'h66, 0, 0, 0, 0, 1);
        run_instr(3'd3, 8'h00, 0, 0, 4, 0, 1);
        run_instr(3'd7, 8'h00, 0, 0, 0, 3, 1);
        run_instr(3'd7, 8'h00, 0, 1, 0, 20, 1);
        run_instr(3'd4, 8'hFF, 0, 0, 0, 0, 1);
        run_instr(3'd0, 8'h00, 0, 0, 0, 0, 1);
        run_instr(3'd2, 8'h00, 0, 0, 2, 0, 0);
        run_instr(3'd1, 8'h00, 0, 2, 0, 0, 1);

        // Randomized instruction stream.
        for (int k = 0; k < 40; k++)
            run_instr(3'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 5) != 0));

        // Reset in the middle of a data memory handshake.
        instr = {3'd2, 5'd0};
        noise = 0;
        for (int k = 0; k < 10 && !dmem_req; k++) begin
            @(negedge clock);
            imem_ready = 1;
            dmem_ready = 0;
            #1;
        end
        check("mem_reached", dmem_req, 1);
        reset = 1;
        @(posedge clock);
        #1;
        check("rst_mid_mem_dmem_req", dmem_req, 0);
        check("rst_mid_mem_fault", fault, 0);
        check("rst_mid_mem_pc", pc, 0);
        check("rst_mid_mem_strobes", {imem_req, dmem_we, reg_we, instr_done}, 0);
        reset = 0;
        imem_ready = 0;
        exp_pc = 8'h00;
        @(posedge clock);
        #1;
        check("post_rst_fetch", imem_req, 1);

`ifdef SEQ_WATCHDOG_EN
        // imem_ready stuck low: fault appears once 15 wait cycles have elapsed.
        cyc = 0;
        while (!fault && cyc < 40) begin
            @(negedge clock);
            cyc++;
            imem_ready = 0;
        end
        check("wd_fault_cycle", cyc, 16);
        check("wd_fault_no_req", imem_req, 0);
        imem_ready = 1;
        repeat (3) @(posedge clock);
        #1;
        check("wd_fault_sticky", {fault, imem_req}, 2'b10);
        reset = 1;
        @(posedge clock);
        #1;
        check("wd_fault_cleared", fault, 0);
        reset = 0;
`else
        cyc = 0;
        repeat (25) begin
            @(negedge clock);
            imem_ready = 0;
            if (fault) cyc++;
        end
        check("no_wd_fault", cyc, 0);
        check("unbounded_wait_req", imem_req, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
